uart_rx_fifo: RTL and testbench

Parametrised UART receiver with start-bit validation, configurable frame format and an error-tagged receive FIFO. It sits between the SoC `uart_rx` pin and the peripheral register bus. It replaces the fixed 8N1, 115200-baud receive path with one that is generic in clock rate, baud, data width, parity, stop bits and buffer depth. It also adds framing, parity and overrun detection and recovery from break conditions.

---
 rtl/uart_rx_fifo_if.sv | 29 ++
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: serial line in, show-ahead FIFO read port
// and overrun status out.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                            uart_rx;
  logic                            rd_en;
  logic                            err_clr;
  logic                            rd_valid;
  logic [DATA_BITS-1:0]            rd_data;
  logic                            rd_frame_err;
  logic                            rd_parity_err;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;
  logic                            overrun_pulse;
  logic                            overrun_flag;

  modport slave (
    input  uart_rx, rd_en, err_clr,
    output rd_valid, rd_data, rd_frame_err, rd_parity_err,
           fifo_count, overrun_pulse, overrun_flag
  );

  modport master (
    output uart_rx, rd_en, err_clr,
    input  rd_valid, rd_data, rd_frame_err, rd_parity_err,
           fifo_count, overrun_pulse, overrun_flag
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit validation, configurable frame format and an
// error-tagged show-ahead receive FIFO with overrun detection.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  rxBus_io
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV + 1);
  localparam int IW   = $clog2(DATA_BITS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [IW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
  logic                 frameErr_q, frameErr_d;
  logic                 parityErr_q, parityErr_d;
  logic                 rxs, tick, wrEn;
  logic [EW-1:0]        wrEntry;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q;
  logic                 ovrPulse_q, ovrFlag_q;
  logic                 doRd, doWr, overrun, notEmpty, full;

  assign rxs  = sync_q[1];
  assign tick = (tmr_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      tmr_q       <= '0;
      bitIdx_q    <= '0;
      shiftReg_q  <= '0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxBus_io.uart_rx};
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bitIdx_q    <= bitIdx_d;
      shiftReg_q  <= shiftReg_d;
      frameErr_q  <= frameErr_d;
      parityErr_q <= parityErr_d;
    end
  end

  // The timer free-runs down to zero; each state reloads it on the sample it acts on.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tick ? '0 : tmr_q - 1'b1;
    bitIdx_d    = bitIdx_q;
    shiftReg_d  = shiftReg_q;
    frameErr_d  = frameErr_q;
    parityErr_d = parityErr_q;
    wrEn        = 1'b0;
    wrEntry     = {frameErr_q | ~rxs, parityErr_q, shiftReg_q};
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          tmr_d       = TW'(HALF - 1);
          bitIdx_d    = '0;
          frameErr_d  = 1'b0;
          parityErr_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (tick) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            tmr_d   = TW'(DIV - 1);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shiftReg_d = {rxs, shiftReg_q[DATA_BITS-1:1]};
          tmr_d      = TW'(DIV - 1);
          if (bitIdx_q == IW'(DATA_BITS - 1)) begin
            bitIdx_d = '0;
            state_d  = (PARITY != 0) ? PAR : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          if (PARITY == 1) parityErr_d = ~((^shiftReg_q) ^ rxs);
          else             parityErr_d = (^shiftReg_q) ^ rxs;
          tmr_d   = TW'(DIV - 1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (!rxs) frameErr_d = 1'b1;
          if (bitIdx_q == IW'(STOP_BITS - 1)) begin
            wrEn    = 1'b1;
            state_d = rxs ? IDLE : WAIT_HIGH;
          end else begin
            tmr_d    = TW'(DIV - 1);
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a write to a full FIFO alongside a read is accepted.
  assign notEmpty = (count_q != '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign doRd     = rxBus_io.rd_en && notEmpty;
  assign doWr     = wrEn && (!full || doRd);
  assign overrun  = wrEn && full && !doRd;

  always_ff @(posedge clk) begin
    if (doWr) mem_q[wrPtr_q] <= wrEntry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ovrPulse_q <= 1'b0;
      ovrFlag_q  <= 1'b0;
    end else begin
      if (doWr) wrPtr_q <= wrPtr_q + 1'b1;
      if (doRd) rdPtr_q <= rdPtr_q + 1'b1;
      if (doWr && !doRd)      count_q <= count_q + 1'b1;
      else if (doRd && !doWr) count_q <= count_q - 1'b1;
      ovrPulse_q <= overrun;
      if (overrun)               ovrFlag_q <= 1'b1;
      else if (rxBus_io.err_clr) ovrFlag_q <= 1'b0;
    end
  end

  assign rxBus_io.rd_valid      = notEmpty;
  assign rxBus_io.rd_data       = notEmpty ? mem_q[rdPtr_q][DATA_BITS-1:0] : '0;
  assign rxBus_io.rd_parity_err = notEmpty ? mem_q[rdPtr_q][DATA_BITS] : 1'b0;
  assign rxBus_io.rd_frame_err  = notEmpty ? mem_q[rdPtr_q][DATA_BITS+1] : 1'b0;
  assign rxBus_io.fifo_count    = count_q;
  assign rxBus_io.overrun_pulse = ovrPulse_q;
  assign rxBus_io.overrun_flag  = ovrFlag_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default 8N1 instance for the directed scenarios and a
// fast 7E2 instance for parity checks and randomized traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int BIT0 = 434;
  localparam int BIT1 = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
  uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus1 ();

  uart_rx_fifo dut0 (.clk(clk), .rst(rst), .rxBus_io(bus0.slave));

  uart_rx_fifo #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut1 (.clk(clk), .rst(rst), .rxBus_io(bus1.slave));

  int checks = 0;
  int errors = 0;
  int pulseCnt0 = 0, pulseCnt1 = 0;
  int expOvr0 = 0, expOvr1 = 0;
  logic expFlag0 = 1'b0, expFlag1 = 1'b0;
  logic [10:0] q0[$];
  logic [10:0] q1[$];

  always @(posedge clk) begin
    if (bus0.overrun_pulse === 1'b1) pulseCnt0++;
    if (bus1.overrun_pulse === 1'b1) pulseCnt1++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic driveRx(input int which, input logic v);
    if (which == 0) bus0.uart_rx = v;
    else            bus1.uart_rx = v;
  endtask

  // Serial frame: start, nBits data LSB first, optional parity, nStop stop bits.
  task automatic applyStimulus(input int which, input logic [8:0] data, input int nBits,
                               input int usePar, input logic parBit, input int nStop,
                               input logic [1:0] stopBits, input int bitCyc);
    driveRx(which, 1'b0);
    waitCycles(bitCyc);
    for (int k = 0; k < nBits; k++) begin
      driveRx(which, data[k]);
      waitCycles(bitCyc);
    end
    if (usePar != 0) begin
      driveRx(which, parBit);
      waitCycles(bitCyc);
    end
    for (int j = 0; j < nStop; j++) begin
      driveRx(which, stopBits[j]);
      waitCycles(bitCyc);
    end
  endtask

  task automatic modelWrite(input int which, input logic fe, input logic pe, input logic [8:0] d);
    if (which == 0) begin
      if (q0.size() == 4) begin expOvr0++; expFlag0 = 1'b1; end
      else q0.push_back({fe, pe, d});
    end else begin
      if (q1.size() == 4) begin expOvr1++; expFlag1 = 1'b1; end
      else q1.push_back({fe, pe, d});
    end
  endtask

  task automatic checkHead(input int which, input string tag);
    logic v, fe, pe, fl;
    logic [8:0] d;
    logic [3:0] c;
    logic [10:0] e;
    int n, pc, eo;
    logic ef;
    if (which == 0) begin
      v = bus0.rd_valid; d = {1'b0, bus0.rd_data}; fe = bus0.rd_frame_err;
      pe = bus0.rd_parity_err; c = {1'b0, bus0.fifo_count}; fl = bus0.overrun_flag;
      n = q0.size(); e = (n != 0) ? q0[0] : 11'd0; pc = pulseCnt0; eo = expOvr0; ef = expFlag0;
    end else begin
      v = bus1.rd_valid; d = {2'b0, bus1.rd_data}; fe = bus1.rd_frame_err;
      pe = bus1.rd_parity_err; c = {1'b0, bus1.fifo_count}; fl = bus1.overrun_flag;
      n = q1.size(); e = (n != 0) ? q1[0] : 11'd0; pc = pulseCnt1; eo = expOvr1; ef = expFlag1;
    end
    checkOutput({tag, ".valid"}, v, (n != 0));
    checkOutput({tag, ".count"}, c, n);
    checkOutput({tag, ".data"}, d, e[8:0]);
    checkOutput({tag, ".frameErr"}, fe, e[10]);
    checkOutput({tag, ".parityErr"}, pe, e[9]);
    checkOutput({tag, ".ovrFlag"}, fl, ef);
    checkOutput({tag, ".ovrPulses"}, pc, eo);
  endtask

  task automatic popHead(input int which);
    if (which == 0) bus0.rd_en = 1'b1; else bus1.rd_en = 1'b1;
    @(negedge clk);
    if (which == 0) bus0.rd_en = 1'b0; else bus1.rd_en = 1'b0;
    if (which == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic clearErr(input int which);
    if (which == 0) bus0.err_clr = 1'b1; else bus1.err_clr = 1'b1;
    @(negedge clk);
    if (which == 0) begin bus0.err_clr = 1'b0; expFlag0 = 1'b0; end
    else            begin bus1.err_clr = 1'b0; expFlag1 = 1'b0; end
  endtask

  task automatic resetModels();
    q0.delete(); q1.delete();
    expFlag0 = 1'b0; expFlag1 = 1'b0;
  endtask

  initial begin
    logic [8:0] d;
    logic pb, pe;
    logic [1:0] sb;
    int nPop;

    bus0.uart_rx = 1'b1; bus0.rd_en = 1'b0; bus0.err_clr = 1'b0;
    bus1.uart_rx = 1'b1; bus1.rd_en = 1'b0; bus1.err_clr = 1'b0;
    rst = 1'b1;
    waitCycles(3);
    checkHead(0, "reset0");
    checkHead(1, "reset1");
    rst = 1'b0;
    waitCycles(200);

    applyStimulus(0, 9'h055, 8, 0, 1'b0, 1, 2'b01, BIT0);
    modelWrite(0, 1'b0, 1'b0, 9'h055);
    checkHead(0, "frame55");
    popHead(0);
    checkHead(0, "frame55Pop");

    // A 100 ns low pulse must be rejected as a false start.
    driveRx(0, 1'b0);
    #100;
    driveRx(0, 1'b1);
    waitCycles(BIT0 / 2 + 10);
    checkHead(0, "glitch");

    // Break: bad stop bit, then the line stays low for 20 bit times.
    applyStimulus(0, 9'h0A3, 8, 0, 1'b0, 1, 2'b00, BIT0);
    modelWrite(0, 1'b1, 1'b0, 9'h0A3);
    waitCycles(20 * BIT0);
    driveRx(0, 1'b1);
    waitCycles(BIT0);
    checkHead(0, "breakA3");
    applyStimulus(0, 9'h00F, 8, 0, 1'b0, 1, 2'b01, BIT0);
    modelWrite(0, 1'b0, 1'b0, 9'h00F);
    popHead(0);
    checkHead(0, "after0F");
    popHead(0);
    checkHead(0, "breakDrained");

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 9'(i), 8, 0, 1'b0, 1, 2'b01, BIT0);
      modelWrite(0, 1'b0, 1'b0, 9'(i));
    end
    checkHead(0, "overrunFull");
    for (int i = 0; i < 4; i++) begin
      popHead(0);
      checkHead(0, $sformatf("overrunRead%0d", i));
    end
    clearErr(0);
    checkHead(0, "overrunClr");

    applyStimulus(1, 9'h007, 7, 1, 1'b0, 2, 2'b11, BIT1);
    modelWrite(1, 1'b0, 1'b1, 9'h007);
    checkHead(1, "parityBad");
    popHead(1);
    applyStimulus(1, 9'h007, 7, 1, 1'b1, 2, 2'b11, BIT1);
    modelWrite(1, 1'b0, 1'b0, 9'h007);
    checkHead(1, "parityGood");
    popHead(1);

    // Reset in the middle of the data bits discards the frame entirely.
    driveRx(0, 1'b0);
    waitCycles(BIT0);
    for (int k = 0; k < 4; k++) begin
      driveRx(0, k[0]);
      waitCycles(BIT0);
    end
    rst = 1'b1;
    driveRx(0, 1'b1);
    resetModels();
    waitCycles(2);
    checkHead(0, "rstAbortIn");
    checkOutput("rstAbortIn.pulse", bus0.overrun_pulse, 1'b0);
    rst = 1'b0;
    waitCycles(2000);
    checkHead(0, "rstAbortIdle");

    for (int it = 0; it < 60; it++) begin
      d  = 9'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      pe = 1'(($countones(d) + int'(pb)) % 2);
      applyStimulus(1, d, 7, 1, pb, 2, sb, BIT1);
      driveRx(1, 1'b1);
      waitCycles(BIT1);
      modelWrite(1, (sb != 2'b11), pe, d);
      checkHead(1, $sformatf("rand%0d", it));
      nPop = $urandom_range(0, 2);
      for (int p = 0; p < nPop; p++) begin
        if (q1.size() != 0) begin
          popHead(1);
          checkHead(1, $sformatf("rand%0dPop%0d", it, p));
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        clearErr(1);
        checkHead(1, $sformatf("rand%0dClr", it));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
